// File: rtl/bayer_mosaic_tx_pkg.sv
// Shared types and constants for the Bayer re-mosaic transmitter.
//   sample_t    : one raw Bayer sample
//   gb_word_t   : line-buffer word holding the {G,B} pair replayed on the odd row
//   row_state_e : row-level FSM encoding
//   PAT_*       : quad-order selection for the PATTERN parameter
package bayer_pkg;

   localparam int SAMPLE_W = 12;

   typedef logic [SAMPLE_W-1:0] sample_t;

   typedef struct packed {
      sample_t g;
      sample_t b;
   } gb_word_t;

   typedef enum logic [0:0] {
      ROW_EVEN = 1'b0,
      ROW_ODD  = 1'b1
   } row_state_e;

   localparam int PAT_GRBG = 0;
   localparam int PAT_RGGB = 1;

endpackage

// File: rtl/bayer_mosaic_tx_if.sv
// Pixel-in / raw-out bundle of the Bayer re-mosaic transmitter.
//   iRed/iGreen/iBlue/iDVAL : RGB pixel offered by the source
//   oREADY                  : pixel taken on a cycle with iDVAL & oREADY
//   oDATA/oDVAL             : raw Bayer sample and its valid
//   oX_Cont/oY_Cont         : output column/row of the current sample
//   oFrameDone              : pulse alongside the last sample of a frame
// master = pixel source side, slave = transmitter side.
interface bayer_mosaic_tx_if #(
   parameter int DW = 12
) ();

   logic [DW-1:0] iRed;
   logic [DW-1:0] iGreen;
   logic [DW-1:0] iBlue;
   logic          iDVAL;
   logic          oREADY;
   logic [DW-1:0] oDATA;
   logic          oDVAL;
   logic [10:0]   oX_Cont;
   logic [10:0]   oY_Cont;
   logic          oFrameDone;

   modport master (
      output iRed, iGreen, iBlue, iDVAL,
      input  oREADY, oDATA, oDVAL, oX_Cont, oY_Cont, oFrameDone
   );

   modport slave (
      input  iRed, iGreen, iBlue, iDVAL,
      output oREADY, oDATA, oDVAL, oX_Cont, oY_Cont, oFrameDone
   );

endinterface

// File: rtl/bayer_mosaic_tx_line_ram.sv
// One-line buffer for the odd-row replay.
// Simple dual-port: one write port, one registered read port (1-cycle latency).
//   clk_sys          : clock
//   wr_en/addr/data  : write port
//   rd_en/rd_addr    : read request, rd_data valid the cycle after
// The array carries no reset; every location is written before it is read.
module bayer_line_ram #(
   parameter int DEPTH = 640,
   parameter int WIDTH = 24,
   parameter int AW    = 10
) (
   input  logic             clk_sys,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk_sys) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/bayer_mosaic_tx.sv
// Re-mosaics a half-resolution RGB stream into a full-resolution Bayer raw
// stream. Each accepted pixel becomes a 2x2 quad: the even output row is
// emitted straight away, the odd row is replayed from the line buffer.
//   iCLK : pixel clock
//   iRST : asynchronous active-low reset
//   px   : pixel/raw bundle (slave side), see bayer_mosaic_tx_if
//
// state    | meaning
// ROW_EVEN | accept pixels; phase 0 waits for iDVAL, phase 1 sends 2nd sample
// ROW_ODD  | replay {G,B} from buffer; unprimed cycle issues the first read
module bayer_mosaic_tx
   import bayer_pkg::*;
#(
   parameter int H_IN    = 640,
   parameter int V_IN    = 480,
   parameter int DW      = 12,
   parameter int PATTERN = 0
) (
   input  logic iCLK,
   input  logic iRST,
   bayer_mosaic_tx_if.slave px
);

   localparam int XW = (H_IN > 1) ? $clog2(H_IN) : 1;
   localparam int YW = (V_IN > 1) ? $clog2(V_IN) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(H_IN - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_IN - 1);
   localparam logic [0:0] S_EVEN = ROW_EVEN;
   localparam logic [0:0] S_ODD  = ROW_ODD;
   localparam bit RGGB = (PATTERN == PAT_RGGB);

   logic [0:0]      state;
   logic            phase;
   logic            primed;
   logic [XW-1:0]   x_in;
   logic [YW-1:0]   y_in;
   logic [DW-1:0]   even_hold;

   logic [DW-1:0]   data_q;
   logic            dval_q;
   logic            ready_q;
   logic [10:0]     x_out_q;
   logic [10:0]     y_out_q;
   logic            done_q;

   logic            accept;
   logic            rd_en;
   logic [XW-1:0]   rd_addr;
   logic [2*DW-1:0] wr_data;
   logic [2*DW-1:0] rd_data;
   logic [DW-1:0]   even_first;
   logic [DW-1:0]   even_second;
   logic [DW-1:0]   odd_first;
   logic [DW-1:0]   odd_second;
   logic [10:0]     x2;
   logic [10:0]     y2;

   // The read for column k+1 is issued on the edge that sends the second odd
   // sample of column k: that edge still sees column k in rd_data, and the
   // next column is ready one cycle later, so the row streams without gaps.
   // The unprimed cycle at row start fetches column 0 and is the only bubble.
   always_comb begin
      accept      = px.iDVAL & ready_q & (state == S_EVEN) & ~phase;
      wr_data     = {px.iGreen, px.iBlue};
      rd_en       = (state == S_ODD) & (~primed | (phase & (x_in != X_LAST)));
      rd_addr     = x_in + XW'(primed);
      even_first  = RGGB ? px.iRed   : px.iGreen;
      even_second = RGGB ? px.iGreen : px.iRed;
      odd_first   = RGGB ? rd_data[2*DW-1:DW] : rd_data[DW-1:0];
      odd_second  = RGGB ? rd_data[DW-1:0]    : rd_data[2*DW-1:DW];
      x2          = 11'(x_in) << 1;
      y2          = 11'(y_in) << 1;
   end

   bayer_line_ram #(
      .DEPTH (H_IN),
      .WIDTH (2*DW),
      .AW    (XW)
   ) u_line_ram (
      .clk_sys (iCLK),
      .wr_en   (accept),
      .wr_addr (x_in),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state     <= S_EVEN;
         phase     <= 1'b0;
         primed    <= 1'b0;
         x_in      <= '0;
         y_in      <= '0;
         even_hold <= '0;
         data_q    <= '0;
         dval_q    <= 1'b0;
         ready_q   <= 1'b0;
         x_out_q   <= '0;
         y_out_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state == S_EVEN) begin
            if (!phase) begin
               if (accept) begin
                  data_q    <= even_first;
                  even_hold <= even_second;
                  dval_q    <= 1'b1;
                  x_out_q   <= x2;
                  y_out_q   <= y2;
                  phase     <= 1'b1;
                  ready_q   <= 1'b0;
               end else begin
                  dval_q  <= 1'b0;
                  ready_q <= 1'b1;
               end
            end else begin
               data_q  <= even_hold;
               dval_q  <= 1'b1;
               x_out_q <= x2 | 11'd1;
               phase   <= 1'b0;
               if (x_in == X_LAST) begin
                  x_in    <= '0;
                  state   <= S_ODD;
                  ready_q <= 1'b0;
               end else begin
                  x_in    <= x_in + 1'b1;
                  ready_q <= 1'b1;
               end
            end
         end else begin
            if (!primed) begin
               primed <= 1'b1;
               dval_q <= 1'b0;
            end else if (!phase) begin
               data_q  <= odd_first;
               dval_q  <= 1'b1;
               x_out_q <= x2;
               y_out_q <= y2 | 11'd1;
               phase   <= 1'b1;
            end else begin
               data_q  <= odd_second;
               dval_q  <= 1'b1;
               x_out_q <= x2 | 11'd1;
               phase   <= 1'b0;
               if (x_in == X_LAST) begin
                  x_in    <= '0;
                  primed  <= 1'b0;
                  state   <= S_EVEN;
                  ready_q <= 1'b1;
                  if (y_in == Y_LAST) begin
                     y_in   <= '0;
                     done_q <= 1'b1;
                  end else begin
                     y_in <= y_in + 1'b1;
                  end
               end else begin
                  x_in <= x_in + 1'b1;
               end
            end
         end
      end
   end

   assign px.oDATA      = data_q;
   assign px.oDVAL      = dval_q;
   assign px.oREADY     = ready_q;
   assign px.oX_Cont    = x_out_q;
   assign px.oY_Cont    = y_out_q;
   assign px.oFrameDone = done_q;

endmodule

// File: tb/tb_bayer_mosaic_tx.sv
// Directed bench for bayer_mosaic_tx, H_IN=4, V_IN=2.
// dut0 runs PATTERN 0 (GRBG), dut1 runs PATTERN 1 (RGGB) on the same stimulus.
// Pixel n carries R=0x100+n, G=0x200+n, B=0x300+n.
module tb_bayer_mosaic_tx;

   localparam int H  = 4;
   localparam int V  = 2;
   localparam int DW = 12;

   // Hand-computed rows for input line 0; line 1 is the same plus 4.
   localparam logic [11:0] TAB0 [2][8] = '{
      '{12'h200, 12'h100, 12'h201, 12'h101, 12'h202, 12'h102, 12'h203, 12'h103},
      '{12'h300, 12'h200, 12'h301, 12'h201, 12'h302, 12'h202, 12'h303, 12'h203}
   };
   localparam logic [11:0] TAB1 [2][8] = '{
      '{12'h100, 12'h200, 12'h101, 12'h201, 12'h102, 12'h202, 12'h103, 12'h203},
      '{12'h200, 12'h300, 12'h201, 12'h301, 12'h202, 12'h302, 12'h203, 12'h303}
   };

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bayer_mosaic_tx_if #(.DW(DW)) bus0 ();
   bayer_mosaic_tx_if #(.DW(DW)) bus1 ();

   assign bus1.iRed   = bus0.iRed;
   assign bus1.iGreen = bus0.iGreen;
   assign bus1.iBlue  = bus0.iBlue;
   assign bus1.iDVAL  = bus0.iDVAL;

   bayer_mosaic_tx #(.H_IN(H), .V_IN(V), .DW(DW), .PATTERN(0)) dut0 (
      .iCLK (clk),
      .iRST (rst_n),
      .px   (bus0)
   );

   bayer_mosaic_tx #(.H_IN(H), .V_IN(V), .DW(DW), .PATTERN(1)) dut1 (
      .iCLK (clk),
      .iRST (rst_n),
      .px   (bus1)
   );

   int checks = 0;
   int failures = 0;
   int n = 0;
   logic drv = 1'b0;

   logic        s0_dval, s0_ready, s0_done, s1_dval;
   logic [11:0] s0_data, s1_data;
   logic [10:0] s0_x, s0_y, s1_x, s1_y;

   task automatic drive_inputs();
      bus0.iRed   = 12'(32'h100 + n);
      bus0.iGreen = 12'(32'h200 + n);
      bus0.iBlue  = 12'(32'h300 + n);
      bus0.iDVAL  = drv;
   endtask

   // Sample outputs mid-cycle, then account for a handshake on the edge.
   task automatic step();
      @(negedge clk);
      s0_dval  = bus0.oDVAL;
      s0_ready = bus0.oREADY;
      s0_done  = bus0.oFrameDone;
      s0_data  = bus0.oDATA;
      s0_x     = bus0.oX_Cont;
      s0_y     = bus0.oY_Cont;
      s1_dval  = bus1.oDVAL;
      s1_data  = bus1.oDATA;
      s1_x     = bus1.oX_Cont;
      s1_y     = bus1.oY_Cont;
      @(posedge clk);
      if (drv && s0_ready) n++;
      #1 drive_inputs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drv = 1'b0;
      n = 0;
      drive_inputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      drv = 1'b0;
      n = 0;
      drive_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus0.oDVAL, bus0.oREADY, bus0.oFrameDone, bus0.oDATA, bus0.oX_Cont, bus0.oY_Cont} !== '0) begin
         failures++;
         $display("FAIL reset_p0 got dval=%b ready=%b done=%b data=%h x=%0d y=%0d exp all zero",
                  bus0.oDVAL, bus0.oREADY, bus0.oFrameDone, bus0.oDATA, bus0.oX_Cont, bus0.oY_Cont);
      end
      checks++;
      if ({bus1.oDVAL, bus1.oREADY, bus1.oFrameDone, bus1.oDATA, bus1.oX_Cont, bus1.oY_Cont} !== '0) begin
         failures++;
         $display("FAIL reset_p1 got dval=%b ready=%b data=%h exp all zero",
                  bus1.oDVAL, bus1.oREADY, bus1.oDATA);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus0.oREADY !== 1'b1 || bus0.oDVAL !== 1'b0) begin
         failures++;
         $display("FAIL reset_release got ready=%b dval=%b exp ready=1 dval=0", bus0.oREADY, bus0.oDVAL);
      end
   endtask

   task automatic test_frame();
      int got0, got1, gaps, done_cnt, done_idx, row, col;
      logic started, found;
      logic [11:0] exp;
      got0 = 0; got1 = 0; gaps = 0; done_cnt = 0; done_idx = -1;
      started = 1'b0;
      do_reset();
      drv = 1'b1;
      drive_inputs();
      for (int k = 0; k < 300 && (got0 < 32 || got1 < 32); k++) begin
         step();
         if (s0_done) begin
            done_cnt++;
            done_idx = s0_dval ? got0 : -1;
         end
         if (s0_dval && got0 < 32) begin
            row = got0 / 8;
            col = got0 % 8;
            exp = TAB0[row % 2][col] + 12'((row / 2) * 4);
            checks++;
            if (s0_data !== exp || s0_x !== 11'(col) || s0_y !== 11'(row)) begin
               failures++;
               $display("FAIL frame_p0 idx=%0d got data=%h x=%0d y=%0d exp data=%h x=%0d y=%0d",
                        got0, s0_data, s0_x, s0_y, exp, col, row);
            end
            if (row % 2 == 1 && col != 7) begin
               checks++;
               if (s0_ready !== 1'b0) begin
                  failures++;
                  $display("FAIL ready_odd idx=%0d got ready=%b exp 0", got0, s0_ready);
               end
            end
            got0++;
            started = 1'b1;
         end else if (started && got0 < 32) begin
            gaps++;
            checks++;
            if (s0_ready !== 1'b0) begin
               failures++;
               $display("FAIL ready_bubble got ready=%b exp 0", s0_ready);
            end
         end
         if (s1_dval && got1 < 32) begin
            row = got1 / 8;
            col = got1 % 8;
            exp = TAB1[row % 2][col] + 12'((row / 2) * 4);
            checks++;
            if (s1_data !== exp || s1_x !== 11'(col) || s1_y !== 11'(row)) begin
               failures++;
               $display("FAIL frame_p1 idx=%0d got data=%h x=%0d y=%0d exp data=%h x=%0d y=%0d",
                        got1, s1_data, s1_x, s1_y, exp, col, row);
            end
            got1++;
         end
      end
      checks++;
      if (got0 != 32 || got1 != 32) begin
         failures++;
         $display("FAIL frame_timeout got samples p0=%0d p1=%0d exp 32", got0, got1);
      end
      checks++;
      if (gaps != 2) begin
         failures++;
         $display("FAIL frame_bubbles got %0d exp 2", gaps);
      end
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         if (s0_done) begin
            done_cnt++;
            done_idx = -1;
         end
         if (s0_dval) found = 1'b1;
      end
      checks++;
      if (done_cnt != 1 || done_idx != 31) begin
         failures++;
         $display("FAIL frame_done got pulses=%0d at_idx=%0d exp pulses=1 at_idx=31", done_cnt, done_idx);
      end
      checks++;
      if (!found || s0_data !== 12'h208 || s0_x !== 11'd0 || s0_y !== 11'd0) begin
         failures++;
         $display("FAIL next_frame got found=%b data=%h x=%0d y=%0d exp data=208 x=0 y=0",
                  found, s0_data, s0_x, s0_y);
      end
   endtask

   task automatic test_stall();
      int got, gap_len, gap_before, rc, mode;
      got = 0; gap_len = 0; gap_before = -1; rc = 0; mode = 0;
      do_reset();
      drv = 1'b1;
      drive_inputs();
      for (int k = 0; k < 200 && got < 8; k++) begin
         step();
         if (s0_dval) begin
            if (got == 4) gap_before = gap_len;
            checks++;
            if (s0_data !== TAB0[0][got] || s0_x !== 11'(got) || s0_y !== 11'd0) begin
               failures++;
               $display("FAIL stall_data idx=%0d got data=%h x=%0d y=%0d exp data=%h x=%0d y=0",
                        got, s0_data, s0_x, s0_y, TAB0[0][got], got);
            end
            got++;
            gap_len = 0;
         end else if (got > 0) begin
            gap_len++;
            if (got == 4) begin
               checks++;
               if (s0_data !== 12'h101) begin
                  failures++;
                  $display("FAIL stall_hold got data=%h exp 101", s0_data);
               end
            end
         end
         if (mode == 0 && n == 2) begin
            drv = 1'b0;
            drive_inputs();
            mode = 1;
         end else if (mode == 1) begin
            if (s0_ready) rc++;
            if (rc == 3) begin
               drv = 1'b1;
               drive_inputs();
               mode = 2;
            end
         end
      end
      checks++;
      if (got != 8 || gap_before != 3) begin
         failures++;
         $display("FAIL stall_gap got samples=%0d gap=%0d exp samples=8 gap=3", got, gap_before);
      end
   endtask

   task automatic test_odd_row();
      int viol;
      int n_at_odd;
      logic found;
      viol = 0; n_at_odd = -1; found = 1'b0;
      do_reset();
      drv = 1'b1;
      drive_inputs();
      for (int k = 0; k < 100 && !found; k++) begin
         step();
         if (s0_dval && s0_y == 11'd1) begin
            if (n_at_odd < 0) n_at_odd = n;
            if (s0_x == 11'd7) found = 1'b1;
            else if (s0_ready !== 1'b0) viol++;
         end
      end
      checks++;
      if (!found || n_at_odd != 4 || viol != 0) begin
         failures++;
         $display("FAIL odd_hold got found=%b accepted=%0d ready_violations=%0d exp found=1 accepted=4 violations=0",
                  found, n_at_odd, viol);
      end
      step();
      checks++;
      if (s0_dval !== 1'b1 || s0_data !== 12'h204 || s0_x !== 11'd0 || s0_y !== 11'd2 || n != 5) begin
         failures++;
         $display("FAIL odd_next got dval=%b data=%h x=%0d y=%0d accepted=%0d exp dval=1 data=204 x=0 y=2 accepted=5",
                  s0_dval, s0_data, s0_x, s0_y, n);
      end
   endtask

   task automatic test_reset_mid();
      logic found;
      int got;
      found = 1'b0;
      got = 0;
      do_reset();
      drv = 1'b1;
      drive_inputs();
      for (int k = 0; k < 100 && !found; k++) begin
         step();
         if (s0_dval && s0_y == 11'd1 && s0_x == 11'd2) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL reset_mid_reach got found=0 exp 1");
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus0.oDVAL, bus0.oREADY, bus0.oFrameDone, bus0.oDATA, bus0.oX_Cont, bus0.oY_Cont} !== '0) begin
         failures++;
         $display("FAIL reset_mid_async got dval=%b ready=%b data=%h x=%0d y=%0d exp all zero",
                  bus0.oDVAL, bus0.oREADY, bus0.oDATA, bus0.oX_Cont, bus0.oY_Cont);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n = 16;
      drive_inputs();
      for (int k = 0; k < 100 && got < 8; k++) begin
         step();
         if (s0_dval) begin
            checks++;
            if (s0_data !== TAB0[0][got] + 12'd16 || s0_x !== 11'(got) || s0_y !== 11'd0) begin
               failures++;
               $display("FAIL reset_mid_resume idx=%0d got data=%h x=%0d y=%0d exp data=%h x=%0d y=0",
                        got, s0_data, s0_x, s0_y, TAB0[0][got] + 12'd16, got);
            end
            got++;
         end
      end
      checks++;
      if (got != 8) begin
         failures++;
         $display("FAIL reset_mid_timeout got samples=%0d exp 8", got);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_stall();
      test_odd_row();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no finish exp finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule
